wishbone_arbiter: RTL and testbench
===================================

# wishbone_arbiter

- Parametrised N-master to 1-slave Wishbone classic arbiter.
- Generalises the single point-to-point Wishbone link to NUM_MASTERS requesters sharing one slave port.
- Round-robin fairness; grant held for the whole `cyc` cycle; registered grant decision.
- Sits between CPU/DMA masters and the shared interconnect or memory slave.

## Interface

Parameters:
- NUM_MASTERS, 2, number of master ports; legal range 1..16.
- DATA_WIDTH, 32, data bus width in bits.
- ADDR_WIDTH, 32, address bus width in bits.
- GRANULARITY, 8, select granularity in bits; 8, 16 or 32 only. Any other value, or NUM_MASTERS outside range, triggers `$fatal` at elaboration/initial.

Ports (SEL_W = DATA_WIDTH/GRANULARITY; master vectors are flattened, master i occupies slice i):
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- m_cyc_i  in  NUM_MASTERS  per-master cycle request
- m_stb_i  in  NUM_MASTERS  per-master strobe
- m_we_i  in  NUM_MASTERS  per-master write enable
- m_adr_i  in  NUM_MASTERS*ADDR_WIDTH  per-master address
- m_dat_i  in  NUM_MASTERS*DATA_WIDTH  per-master write data
- m_sel_i  in  NUM_MASTERS*SEL_W  per-master byte select
- m_dat_o  out  DATA_WIDTH  read data, broadcast to all masters
- m_ack_o  out  NUM_MASTERS  per-master acknowledge
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave control
- s_adr_o  out  ADDR_WIDTH  slave address
- s_dat_o  out  DATA_WIDTH  slave write data
- s_sel_o  out  SEL_W  slave select
- s_dat_i  in  DATA_WIDTH  slave read data
- s_ack_i  in  1  slave acknowledge
- grant_o  out  NUM_MASTERS  one-hot current owner; all-zero when idle
- busy_o  out  1  high while a master owns the bus

## Operation

State:
- Registered `owner` index, `granted` flag, `last` pointer.
- IDLE (`granted`=0): no owner.
- OWNED (`granted`=1): `owner` valid.

Arbitration, evaluated every cycle when in IDLE, or when in OWNED and `m_cyc_i[owner]`=0:
- Search requesters with `m_cyc_i` high, starting at `last`+1 and wrapping modulo NUM_MASTERS.
- First hit found: next state OWNED, `owner` = hit, `last` = hit.
- No hit: next state IDLE; `last` unchanged.
- While in OWNED with `m_cyc_i[owner]`=1: no re-arbitration. Other requests wait regardless of their priority.

Datapath (combinational from the registered `owner`):
- s_cyc_o = granted & m_cyc_i[owner].
- s_stb_o = s_cyc_o & m_stb_i[owner].
- s_we_o, s_adr_o, s_dat_o, s_sel_o = owner's slice when granted; all zero otherwise.
- m_ack_o[i] = s_ack_i & granted & (owner==i) & m_cyc_i[i]. All other bits 0.
- An ack arriving while idle is dropped.
- m_dat_o = s_dat_i unconditionally.
- grant_o = one-hot(owner) when granted; busy_o = granted.

## Timing

- Reset, asynchronous while rst_i=0:
  - `granted`=0; `last`=NUM_MASTERS-1, so master 0 has first priority.
  - Consequently all s_* outputs, m_ack_o, grant_o and busy_o are 0. m_dat_o follows s_dat_i.
  - Asserting reset mid-transaction drops s_cyc_o in the same instant; the slave sees the cycle aborted.
- Grant latency: m_cyc_i rises in cycle t while IDLE → grant_o and s_cyc_o high in cycle t+1.
- Handover: owner drops cyc in cycle t (s_cyc_o low in t, combinationally) → new owner granted in t+1. No idle bubble beyond that one cycle.
- Owner drops cyc and re-raises it in the next cycle: treated as a new request, subject to round-robin.
- Simultaneous requests from all masters at reset release: grant order 0,1,…,N-1,0.
- Ack is passed through combinationally (zero latency). Block-cycle transfers (multiple stb/ack under one cyc) are kept intact.
- NUM_MASTERS=1: behaves as a pass-through with the 1-cycle grant latency.

## Test plan

- Reset: drive all inputs high with rst_i=0 → grant_o=0, s_cyc_o=0, s_adr_o=0, m_ack_o=0. Release → master 0 granted on the next edge.
- Single master, NUM_MASTERS=4: master 2 write adr=0x100, dat=0xDEADBEEF, sel=0xF → s_cyc_o rises one cycle later with those values. Slave ack → m_ack_o=4'b0100 in the same cycle.
- Round-robin: all four masters hold cyc, each dropping it after one acked access → grant sequence 0,1,2,3,0. Each handover takes exactly one cycle after cyc drops.
- Lock: master 1 holds cyc for a 4-beat block transfer while master 0 requests → grant_o stays 4'b0010 for all 4 acks. Master 0 is granted the cycle after master 1 drops cyc.
- Stray ack: s_ack_i=1 while idle, and while master 0 is owner → m_ack_o=0 when idle; only bit 0 set when owned.
- Reset mid-cycle: master 3 owns with stb high; pulse rst_i low asynchronously between edges → s_cyc_o and s_stb_o fall immediately. After release, pending master 0 is granted first.

Source files
------------

// File: rtl/wishbone_arbiter.sv
// N-master to 1-slave Wishbone classic arbiter: round-robin, grant held for the
// whole cyc, registered grant decision with a combinational slave-side datapath.
module wishbone_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int GRANULARITY = 8,
    localparam int SEL_W = DATA_WIDTH / GRANULARITY
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_MASTERS-1:0]        m_cyc_i,
    input  logic [NUM_MASTERS-1:0]        m_stb_i,
    input  logic [NUM_MASTERS-1:0]        m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
    input  logic [NUM_MASTERS*SEL_W-1:0]  m_sel_i,
    output logic [DATA_WIDTH-1:0]         m_dat_o,
    output logic [NUM_MASTERS-1:0]        m_ack_o,
    output logic                          s_cyc_o,
    output logic                          s_stb_o,
    output logic                          s_we_o,
    output logic [ADDR_WIDTH-1:0]         s_adr_o,
    output logic [DATA_WIDTH-1:0]         s_dat_o,
    output logic [SEL_W-1:0]              s_sel_o,
    input  logic [DATA_WIDTH-1:0]         s_dat_i,
    input  logic                          s_ack_i,
    output logic [NUM_MASTERS-1:0]        grant_o,
    output logic                          busy_o
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    if (NUM_MASTERS < 1 || NUM_MASTERS > 16) begin : g_bad_masters
        $fatal(1, "wishbone_arbiter: NUM_MASTERS must be 1..16");
    end
    if (GRANULARITY != 8 && GRANULARITY != 16 && GRANULARITY != 32) begin : g_bad_gran
        $fatal(1, "wishbone_arbiter: GRANULARITY must be 8, 16 or 32");
    end

    typedef enum logic {IDLE, OWNED} state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [NUM_MASTERS-1:0] grant_vec;
    logic                   owner_cyc;
    int                     cand;
    logic                   found;

    logic [ADDR_WIDTH-1:0]  adr_masked [NUM_MASTERS];
    logic [DATA_WIDTH-1:0]  dat_masked [NUM_MASTERS];
    logic [SEL_W-1:0]       sel_masked [NUM_MASTERS];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_grant
        assign grant_vec[gi] = (state_q == OWNED) && (owner_q == IDX_W'(gi));
    end

    assign owner_cyc = |(grant_vec & m_cyc_i);

    // Re-arbitrate only when idle or when the owner has released cyc; the
    // search starts one past the last winner and wraps.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        found   = 1'b0;
        cand    = 0;
        if (state_q == IDLE || !owner_cyc) begin
            state_d = IDLE;
            for (int k = 1; k <= NUM_MASTERS; k++) begin
                cand = int'(last_q) + k;
                if (cand >= NUM_MASTERS) begin
                    cand = cand - NUM_MASTERS;
                end
                if (!found && |(m_cyc_i & (NUM_MASTERS'(1) << cand))) begin
                    found   = 1'b1;
                    state_d = OWNED;
                    owner_d = IDX_W'(cand);
                    last_d  = IDX_W'(cand);
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_mask
        assign adr_masked[gi] = grant_vec[gi] ? m_adr_i[gi*ADDR_WIDTH +: ADDR_WIDTH] : '0;
        assign dat_masked[gi] = grant_vec[gi] ? m_dat_i[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
        assign sel_masked[gi] = grant_vec[gi] ? m_sel_i[gi*SEL_W +: SEL_W] : '0;
    end

    // Grant is one-hot (or zero), so OR-reducing the masked slices is a mux.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            s_adr_o = s_adr_o | adr_masked[i];
            s_dat_o = s_dat_o | dat_masked[i];
            s_sel_o = s_sel_o | sel_masked[i];
        end
    end

    assign s_cyc_o = owner_cyc;
    assign s_stb_o = |(grant_vec & m_cyc_i & m_stb_i);
    assign s_we_o  = |(grant_vec & m_we_i);
    assign m_ack_o = {NUM_MASTERS{s_ack_i}} & grant_vec & m_cyc_i;
    assign m_dat_o = s_dat_i;
    assign grant_o = grant_vec;
    assign busy_o  = (state_q == OWNED);

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Self-checking bench for wishbone_arbiter (4 masters): directed scenarios plus
// randomized traffic against a round-robin reference model.
module tb_wishbone_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 4;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    m_cyc, m_stb, m_we;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat;
    logic [N*SW-1:0] m_sel;
    logic [DW-1:0]   s_dat;
    logic            s_ack;
    logic [DW-1:0]   m_dat_o;
    logic [N-1:0]    m_ack_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [SW-1:0]   s_sel_o;
    logic [N-1:0]    grant_o;
    logic            busy_o;

    int checks   = 0;
    int failures = 0;

    // Reference model: owner index (-1 when idle) and last winner.
    int mdl_owner = -1;
    int mdl_last  = N - 1;

    always #5 clk = ~clk;

    wishbone_arbiter #(
        .NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .GRANULARITY(8)
    ) dut (
        .clk_i(clk), .rst_i(rst_n),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat), .s_ack_i(s_ack),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    always @(posedge clk or negedge rst_n) begin : ref_model
        int nxt;
        if (!rst_n) begin
            mdl_owner <= -1;
            mdl_last  <= N - 1;
        end else if (mdl_owner < 0 || !m_cyc[mdl_owner]) begin
            nxt = -1;
            for (int k = 1; k <= N; k++) begin
                if (nxt < 0 && m_cyc[(mdl_last + k) % N]) nxt = (mdl_last + k) % N;
            end
            mdl_owner <= nxt;
            if (nxt >= 0) mdl_last <= nxt;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_cyc = '0; m_stb = '0; m_we = '0;
        m_adr = '0; m_dat = '0; m_sel = '0;
        s_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_cyc = '1; m_stb = '1; m_we = '1;
        m_adr = '1; m_dat = '1; m_sel = '1;
        s_ack = 1'b1; s_dat = 32'hA5A5_5A5A;
        repeat (2) tick();
        checks++; if (grant_o !== 4'b0000) begin failures++; $display("FAIL reset_grant: got %b want 0000", grant_o); end
        checks++; if (s_cyc_o !== 1'b0) begin failures++; $display("FAIL reset_s_cyc: got %b want 0", s_cyc_o); end
        checks++; if (s_stb_o !== 1'b0) begin failures++; $display("FAIL reset_s_stb: got %b want 0", s_stb_o); end
        checks++; if (s_adr_o !== 32'h0) begin failures++; $display("FAIL reset_s_adr: got %h want 0", s_adr_o); end
        checks++; if (m_ack_o !== 4'b0000) begin failures++; $display("FAIL reset_m_ack: got %b want 0000", m_ack_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (m_dat_o !== 32'hA5A5_5A5A) begin failures++; $display("FAIL reset_m_dat: got %h want a5a55a5a", m_dat_o); end
        rst_n = 1'b1;
        tick();
        $display("txn reset_release grant=%b", grant_o);
        checks++; if (grant_o !== 4'b0001) begin failures++; $display("FAIL release_grant: got %b want 0001", grant_o); end
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL release_busy: got %b want 1", busy_o); end
        clear_inputs();
        tick();
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL release_idle: got %b want 0", busy_o); end
    endtask

    task automatic test_single();
        m_cyc[2] = 1'b1; m_stb[2] = 1'b1; m_we[2] = 1'b1;
        m_adr[2*AW +: AW] = 32'h0000_0100;
        m_dat[2*DW +: DW] = 32'hDEAD_BEEF;
        m_sel[2*SW +: SW] = 4'hF;
        #1;
        checks++; if (s_cyc_o !== 1'b0) begin failures++; $display("FAIL single_latency: s_cyc got %b want 0", s_cyc_o); end
        tick();
        checks++; if (grant_o !== 4'b0100) begin failures++; $display("FAIL single_grant: got %b want 0100", grant_o); end
        checks++; if (s_cyc_o !== 1'b1 || s_stb_o !== 1'b1 || s_we_o !== 1'b1) begin failures++; $display("FAIL single_ctrl: cyc/stb/we got %b%b%b want 111", s_cyc_o, s_stb_o, s_we_o); end
        checks++; if (s_adr_o !== 32'h100) begin failures++; $display("FAIL single_adr: got %h want 00000100", s_adr_o); end
        checks++; if (s_dat_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_dat: got %h want deadbeef", s_dat_o); end
        checks++; if (s_sel_o !== 4'hF) begin failures++; $display("FAIL single_sel: got %h want f", s_sel_o); end
        s_ack = 1'b1;
        #1;
        $display("txn single m=2 adr=%h dat=%h ack=%b", s_adr_o, s_dat_o, m_ack_o);
        checks++; if (m_ack_o !== 4'b0100) begin failures++; $display("FAIL single_ack: got %b want 0100", m_ack_o); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        int m;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        m_cyc = '1; m_stb = '1;
        tick();
        for (int i = 0; i < 5; i++) begin
            m = order[i];
            checks++; if (grant_o !== 4'(1 << m)) begin failures++; $display("FAIL rr_grant[%0d]: got %b want %b", i, grant_o, 4'(1 << m)); end
            s_ack = 1'b1;
            #1;
            $display("txn rr step=%0d m=%0d ack=%b", i, m, m_ack_o);
            checks++; if (m_ack_o !== 4'(1 << m)) begin failures++; $display("FAIL rr_ack[%0d]: got %b want %b", i, m_ack_o, 4'(1 << m)); end
            tick();
            s_ack = 1'b0;
            m_cyc[m] = 1'b0;
            #1;
            checks++; if (s_cyc_o !== 1'b0) begin failures++; $display("FAIL rr_drop[%0d]: s_cyc got %b want 0", i, s_cyc_o); end
            tick();
            m_cyc[m] = 1'b1;
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_lock();
        m_cyc = 4'b0010; m_stb = 4'b0010;
        tick();
        checks++; if (grant_o !== 4'b0010) begin failures++; $display("FAIL lock_start: got %b want 0010", grant_o); end
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        for (int b = 0; b < 4; b++) begin
            s_ack = 1'b1;
            #1;
            $display("txn lock beat=%0d grant=%b ack=%b", b, grant_o, m_ack_o);
            checks++; if (grant_o !== 4'b0010) begin failures++; $display("FAIL lock_grant[%0d]: got %b want 0010", b, grant_o); end
            checks++; if (m_ack_o !== 4'b0010) begin failures++; $display("FAIL lock_ack[%0d]: got %b want 0010", b, m_ack_o); end
            tick();
        end
        s_ack = 1'b0;
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        tick();
        checks++; if (grant_o !== 4'b0001) begin failures++; $display("FAIL lock_handover: got %b want 0001", grant_o); end
    endtask

    task automatic test_stray_ack();
        clear_inputs();
        tick();
        s_ack = 1'b1;
        s_dat = $urandom;
        #1;
        checks++; if (m_ack_o !== 4'b0000) begin failures++; $display("FAIL stray_idle: got %b want 0000", m_ack_o); end
        checks++; if (m_dat_o !== s_dat) begin failures++; $display("FAIL stray_dat: got %h want %h", m_dat_o, s_dat); end
        m_cyc[0] = 1'b1;
        tick();
        $display("txn stray owner=0 ack=%b", m_ack_o);
        checks++; if (m_ack_o !== 4'b0001) begin failures++; $display("FAIL stray_owned: got %b want 0001", m_ack_o); end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        m_cyc = 4'b1000; m_stb = 4'b1000;
        tick();
        checks++; if (s_cyc_o !== 1'b1 || s_stb_o !== 1'b1 || grant_o !== 4'b1000) begin failures++; $display("FAIL mid_owned: cyc/stb/grant got %b %b %b want 1 1 1000", s_cyc_o, s_stb_o, grant_o); end
        m_cyc[0] = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin failures++; $display("FAIL mid_abort: cyc/stb got %b %b want 0 0", s_cyc_o, s_stb_o); end
        checks++; if (grant_o !== 4'b0000) begin failures++; $display("FAIL mid_grant: got %b want 0000", grant_o); end
        #1;
        rst_n = 1'b1;
        tick();
        $display("txn reset_mid regrant=%b", grant_o);
        checks++; if (grant_o !== 4'b0001) begin failures++; $display("FAIL mid_regrant: got %b want 0001", grant_o); end
        clear_inputs();
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0]  eg, eack;
        logic          ecyc, estb, ewe;
        logic [AW-1:0] eadr;
        logic [DW-1:0] edat;
        logic [SW-1:0] esel;
        for (int c = 0; c < 400; c++) begin
            if (c % 97 == 50) begin
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                if (m_cyc[i]) m_cyc[i] = ($urandom_range(3) != 0);
                else          m_cyc[i] = ($urandom_range(2) == 0);
            end
            m_stb = N'($urandom); m_we = N'($urandom);
            m_adr = {$urandom, $urandom, $urandom, $urandom};
            m_dat = {$urandom, $urandom, $urandom, $urandom};
            m_sel = 16'($urandom);
            s_ack = 1'($urandom);
            s_dat = $urandom;
            #1;
            if (mdl_owner >= 0) begin
                eg   = N'(1) << mdl_owner;
                ecyc = m_cyc[mdl_owner];
                estb = ecyc & m_stb[mdl_owner];
                ewe  = m_we[mdl_owner];
                eadr = m_adr[mdl_owner*AW +: AW];
                edat = m_dat[mdl_owner*DW +: DW];
                esel = m_sel[mdl_owner*SW +: SW];
                eack = (s_ack && ecyc) ? eg : '0;
            end else begin
                eg = '0; ecyc = 1'b0; estb = 1'b0; ewe = 1'b0;
                eadr = '0; edat = '0; esel = '0; eack = '0;
            end
            checks++; if (grant_o !== eg) begin failures++; $display("FAIL rand_grant c=%0d: got %b want %b", c, grant_o, eg); end
            checks++; if (busy_o !== (mdl_owner >= 0)) begin failures++; $display("FAIL rand_busy c=%0d: got %b want %b", c, busy_o, (mdl_owner >= 0)); end
            checks++; if ({s_cyc_o, s_stb_o, s_we_o} !== {ecyc, estb, ewe}) begin failures++; $display("FAIL rand_ctrl c=%0d: got %b%b%b want %b%b%b", c, s_cyc_o, s_stb_o, s_we_o, ecyc, estb, ewe); end
            checks++; if (s_adr_o !== eadr || s_dat_o !== edat || s_sel_o !== esel) begin failures++; $display("FAIL rand_bus c=%0d: got %h %h %h want %h %h %h", c, s_adr_o, s_dat_o, s_sel_o, eadr, edat, esel); end
            checks++; if (m_ack_o !== eack) begin failures++; $display("FAIL rand_ack c=%0d: got %b want %b", c, m_ack_o, eack); end
            checks++; if (m_dat_o !== s_dat) begin failures++; $display("FAIL rand_mdat c=%0d: got %h want %h", c, m_dat_o, s_dat); end
            if (eack != '0) $display("txn rand c=%0d owner=%0d we=%b adr=%h", c, mdl_owner, ewe, eadr);
            tick();
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        clear_inputs();
        s_dat = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_stray_ack();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
